// File: rtl/pea_pkg.sv
// Shared definitions for the Polynomial Evaluation Accelerator (gen 2).
// Contents:
//   ctrl_tok_t  - layout of a control token {opcode, arg1, arg2}
//   OP_*        - command opcodes
//   ST_*        - status codes reported in status_out[4:0]
//   S_*         - FSM state encoding
//   pw_bits()   - width of FIFO population / free-space ports
//   res_bits()  - width of the result path
package pea_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [2:0] arg1;
    logic [4:0] arg2;
  } ctrl_tok_t;

  localparam logic [7:0] OP_STP = 8'h01;
  localparam logic [7:0] OP_EVP = 8'h02;
  localparam logic [7:0] OP_CLR = 8'h03;

  localparam logic [4:0] ST_OK        = 5'd0;
  localparam logic [4:0] ST_ERR_CMD   = 5'd1;
  localparam logic [4:0] ST_ERR_UNDEF = 5'd2;
  localparam logic [4:0] ST_ERR_DEG   = 5'd3;
  localparam logic [4:0] ST_ERR_SLOT  = 5'd4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_STORE    = 3'd2;
  localparam logic [2:0] S_EV_LOAD  = 3'd3;
  localparam logic [2:0] S_EV_MAC   = 3'd4;
  localparam logic [2:0] S_EV_WRITE = 3'd5;
  localparam logic [2:0] S_DISCARD  = 3'd6;
  localparam logic [2:0] S_STATUS   = 3'd7;

  function automatic int pw_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int res_bits(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/pea_horner_mac.sv
// Horner accumulator: acc <= lo(acc * x) + sext(coef) when enabled.
// Ports:
//   clk     in   clock
//   rst_ni  in   synchronous active-low reset (acc -> 0)
//   clr_i   in   zero the accumulator (start of a new x)
//   en_i    in   perform one multiply-add step
//   x_i     in   W-bit signed evaluation point
//   coef_i  in   W-bit signed coefficient for this step
//   acc_o   out  2W-bit signed accumulator
module pea_horner_mac
  import pea_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [W-1:0]           x_i,
  input  logic [W-1:0]           coef_i,
  output logic [res_bits(W)-1:0] acc_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [3*W-1:0] acc_ext, x_ext;
  logic [3*W-1:0] prod;

  // Full 3W product of sign-extended operands; only the low 2W bits are
  // kept, so overflow wraps silently.
  always_comb begin
    acc_ext = {{W{acc_q[2*W-1]}}, acc_q};
    x_ext   = {{2*W{x_i[W-1]}}, x_i};
    prod    = acc_ext * x_ext;
    acc_d   = prod[2*W-1:0] + {{W{coef_i[W-1]}}, coef_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_ni)    acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pea_top_v2.sv
// Polynomial Evaluation Accelerator, second generation.
// Decodes control tokens, stores coefficient sets per slot and evaluates
// them with Horner's rule, one MAC per cycle.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   control_in / control_pop    FWFT control FIFO head and population
//   data_in / data_pop          FWFT data FIFO head and population
//   result_free_space           room in result FIFO
//   status_free_space           room in status FIFO
//   control_rd_en, data_rd_en   one-cycle pops
//   result_wr_en, status_wr_en  one-cycle pushes
//   result_out                  2W signed polynomial value
//   status_out                  {opcode, arg1, code}
module pea_top_v2
  import pea_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  parameter int num_poly    = 8,
  parameter int max_degree  = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [word_size-1:0]           control_in,
  input  logic [pw_bits(buffer_size)-1:0] control_pop,
  input  logic [word_size-1:0]           data_in,
  input  logic [pw_bits(buffer_size)-1:0] data_pop,
  input  logic [pw_bits(buffer_size)-1:0] result_free_space,
  input  logic [pw_bits(buffer_size)-1:0] status_free_space,
  output logic                           control_rd_en,
  output logic                           data_rd_en,
  output logic                           result_wr_en,
  output logic                           status_wr_en,
  output logic [res_bits(word_size)-1:0] result_out,
  output logic [word_size-1:0]           status_out
);

  localparam int SLOT_WORDS = max_degree + 1;
  localparam int DEPTH      = num_poly * SLOT_WORDS;
  localparam int AW         = $clog2(DEPTH);

  ctrl_tok_t tok;
  assign tok = ctrl_tok_t'(control_in[15:0]);

  logic [2:0]          state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [2:0]          slot_q, slot_d;
  logic [4:0]          arg2_q, arg2_d;
  logic [4:0]          code_q, code_d;
  logic [5:0]          cnt_q, cnt_d;    // tokens (STORE/DISCARD) or x values (EV) left
  logic [4:0]          idx_q, idx_d;    // coefficient index
  logic [4:0]          deg_q, deg_d;    // degree of the slot being evaluated
  logic [word_size-1:0] x_q, x_d;
  logic [num_poly-1:0] valid_q, valid_d;

  logic [4:0]           deg_tab  [num_poly];
  logic [word_size-1:0] coef_ram [DEPTH];
  logic [word_size-1:0] coef_q;

  logic          ram_we, deg_we, mac_clr, mac_en, slot_ok;
  logic [4:0]    rd_idx;
  logic [AW-1:0] wr_addr, rd_addr;

  assign slot_ok = (int'(slot_q) < num_poly);
  assign wr_addr = AW'(int'(slot_q) * SLOT_WORDS + int'(idx_q));
  assign rd_addr = AW'(int'(slot_q) * SLOT_WORDS + int'(rd_idx));

  // Prefetch one coefficient ahead so the registered RAM read lines up with
  // the MAC step; clamp at the top degree so the address stays in the slot.
  always_comb begin
    rd_idx = idx_q + 5'd1;
    if (state_q == S_EV_LOAD)  rd_idx = '0;
    else if (idx_q == deg_q)   rd_idx = idx_q;
  end

  always_comb begin
    state_d = state_q;  op_d  = op_q;   slot_d = slot_q; arg2_d  = arg2_q;
    code_d  = code_q;   cnt_d = cnt_q;  idx_d  = idx_q;  deg_d   = deg_q;
    x_d     = x_q;      valid_d = valid_q;
    control_rd_en = 1'b0; data_rd_en = 1'b0;
    result_wr_en  = 1'b0; status_wr_en = 1'b0;
    ram_we = 1'b0; deg_we = 1'b0; mac_clr = 1'b0; mac_en = 1'b0;
    case (state_q)
      S_IDLE: if (control_pop != '0) begin
        control_rd_en = 1'b1;
        op_d = tok.opcode; slot_d = tok.arg1; arg2_d = tok.arg2;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cnt_d = {1'b0, arg2_q}; idx_d = '0; code_d = ST_OK; state_d = S_STATUS;
        if (op_q != OP_STP && op_q != OP_EVP && op_q != OP_CLR) begin
          code_d = ST_ERR_CMD;
        end else if (!slot_ok) begin
          // Data belonging to the rejected command is still drained.
          code_d = ST_ERR_SLOT;
          if (op_q == OP_STP) begin
            cnt_d = {1'b0, arg2_q} + 6'd1; state_d = S_DISCARD;
          end else if (op_q == OP_EVP && arg2_q != '0) state_d = S_DISCARD;
        end else if (op_q == OP_STP) begin
          cnt_d = {1'b0, arg2_q} + 6'd1;
          if (int'(arg2_q) > max_degree) begin
            code_d = ST_ERR_DEG; state_d = S_DISCARD;
          end else state_d = S_STORE;
        end else if (op_q == OP_EVP) begin
          deg_d = deg_tab[slot_q];
          if (!valid_q[slot_q]) begin
            code_d = ST_ERR_UNDEF;
            if (arg2_q != '0) state_d = S_DISCARD;
          end else if (arg2_q != '0) state_d = S_EV_LOAD;
        end else begin
          valid_d[slot_q] = 1'b0;
        end
      end
      S_STORE: if (data_pop != '0) begin
        data_rd_en = 1'b1; ram_we = 1'b1;
        idx_d = idx_q + 5'd1; cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          valid_d[slot_q] = 1'b1; deg_we = 1'b1; state_d = S_STATUS;
        end
      end
      S_DISCARD: if (data_pop != '0) begin
        data_rd_en = 1'b1; cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_STATUS;
      end
      S_EV_LOAD: if (data_pop != '0) begin
        data_rd_en = 1'b1; x_d = data_in; mac_clr = 1'b1;
        idx_d = '0; state_d = S_EV_MAC;
      end
      S_EV_MAC: begin
        mac_en = 1'b1; idx_d = idx_q + 5'd1;
        if (idx_q == deg_q) state_d = S_EV_WRITE;
      end
      S_EV_WRITE: if (result_free_space != '0) begin
        result_wr_en = 1'b1; cnt_d = cnt_q - 6'd1;
        state_d = (cnt_q == 6'd1) ? S_STATUS : S_EV_LOAD;
      end
      default: if (status_free_space != '0) begin  // S_STATUS
        status_wr_en = 1'b1; state_d = S_IDLE;
      end
    endcase
    // Strobes must stay quiet while reset is held, whatever the old state.
    if (!rst) begin
      control_rd_en = 1'b0; data_rd_en = 1'b0;
      result_wr_en  = 1'b0; status_wr_en = 1'b0;
      ram_we = 1'b0; deg_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE; op_q <= '0; slot_q <= '0; arg2_q <= '0; code_q <= '0;
      cnt_q <= '0; idx_q <= '0; deg_q <= '0; x_q <= '0; valid_q <= '0;
    end else begin
      state_q <= state_d; op_q <= op_d; slot_q <= slot_d; arg2_q <= arg2_d;
      code_q <= code_d; cnt_q <= cnt_d; idx_q <= idx_d; deg_q <= deg_d;
      x_q <= x_d; valid_q <= valid_d;
    end
  end

  // Coefficient storage survives reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (ram_we) coef_ram[wr_addr] <= data_in;
    coef_q <= coef_ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (deg_we) deg_tab[slot_q] <= arg2_q;
  end

  pea_horner_mac #(.W(word_size)) u_mac (
    .clk    (clk),
    .rst_ni (rst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .x_i    (x_q),
    .coef_i (coef_q),
    .acc_o  (result_out)
  );

  assign status_out = {op_q, slot_q, code_q};

endmodule

// File: tb/tb_pea_top_v2.sv
module tb_pea_top_v2;
  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   control_in = '0, data_in = '0;
  logic [PW-1:0] control_pop = '0, data_pop = '0;
  logic [PW-1:0] result_free_space = 11'd16, status_free_space = 11'd16;
  logic          control_rd_en, data_rd_en, result_wr_en, status_wr_en;
  logic [31:0]   result_out;
  logic [15:0]   status_out;

  pea_top_v2 dut (
    .clk(clk), .rst(rst),
    .control_in(control_in), .control_pop(control_pop),
    .data_in(data_in), .data_pop(data_pop),
    .result_free_space(result_free_space), .status_free_space(status_free_space),
    .control_rd_en(control_rd_en), .data_rd_en(data_rd_en),
    .result_wr_en(result_wr_en), .status_wr_en(status_wr_en),
    .result_out(result_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  logic [15:0] cq[$];
  logic [15:0] dq[$];
  logic [31:0] res_q[$];
  logic [15:0] st_q[$];
  int          lat_q[$];
  int vecs = 0, miss = 0, cyc = 0, dpops = 0, viol = 0, strobe_in_rst = 0, last_pop = 0;
  bit c_rd = 0, d_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else $display("  ok   %-14s = %h", tag, got);
  endtask

  task automatic push_cmd(input logic [7:0] op, input logic [2:0] a1, input logic [4:0] a2);
    cq.push_back({op, a1, a2});
  endtask

  task automatic wait_status(input int n);
    int t = 0;
    while (st_q.size() < n && t < 400) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
    check("status_count", st_q.size(), n);
  endtask

  // Observe strobes mid-cycle; strobes are stable between negedge and posedge.
  always @(negedge clk) begin
    c_rd = control_rd_en;
    d_rd = data_rd_en;
    if (!rst && (control_rd_en || data_rd_en || result_wr_en || status_wr_en)) strobe_in_rst++;
    if (control_rd_en && control_pop == '0) viol++;
    if (data_rd_en && data_pop == '0) viol++;
    if (result_wr_en && result_free_space == '0) viol++;
    if (status_wr_en && status_free_space == '0) viol++;
    if (data_rd_en) begin dpops++; last_pop = cyc; end
    if (result_wr_en) begin res_q.push_back(result_out); lat_q.push_back(cyc - last_pop); end
    if (status_wr_en) st_q.push_back(status_out);
  end

  // FWFT FIFO models: pop after the edge, then present the new heads.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (c_rd && cq.size() > 0) void'(cq.pop_front());
    if (d_rd && dq.size() > 0) void'(dq.pop_front());
    c_rd = 0; d_rd = 0;
    #1;
    control_pop = PW'(cq.size());
    control_in  = (cq.size() > 0) ? cq[0] : 16'h0;
    data_pop    = PW'(dq.size());
    data_in     = (dq.size() > 0) ? dq[0] : 16'h0;
  end

  initial begin
    int dp0, r0, s0, t;

    // Reset with tokens already waiting.
    push_cmd(8'h01, 3'd0, 5'd2);
    dq.push_back(16'd3); dq.push_back(16'd2); dq.push_back(16'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", result_out, 32'h0);
    check("rst_status", {16'h0, status_out}, 32'h0);
    check("rst_strobes", {28'h0, control_rd_en, data_rd_en, result_wr_en, status_wr_en}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("first_pop", {31'h0, control_rd_en}, 32'h1);

    // 3x^2+2x+1 at x=2 and x=-1.
    push_cmd(8'h02, 3'd0, 5'd2);
    dq.push_back(16'd2); dq.push_back(16'hFFFF);
    wait_status(2);
    check("evp_x2", res_q[0], 32'd17);
    check("evp_xm1", res_q[1], 32'd2);
    check("evp_latency", lat_q[0], 32'd4);
    check("stp_status", {16'h0, st_q[0]}, 32'h0100);
    check("evp_status", {16'h0, st_q[1]}, 32'h0200);

    // Evaluate an empty slot.
    dp0 = dpops; r0 = res_q.size();
    push_cmd(8'h02, 3'd5, 5'd1);
    dq.push_back(16'd7);
    wait_status(3);
    check("undef_pops", dpops - dp0, 32'd1);
    check("undef_nores", res_q.size() - r0, 32'd0);
    check("undef_status", {16'h0, st_q[2]}, 32'h02A2);

    // 32767*x^2 at x=-32768 wraps to 0xC0000000.
    push_cmd(8'h01, 3'd1, 5'd2);
    dq.push_back(16'h7FFF); dq.push_back(16'h0); dq.push_back(16'h0);
    push_cmd(8'h02, 3'd1, 5'd1);
    dq.push_back(16'h8000);
    wait_status(5);
    check("wrap_result", res_q[2], 32'hC0000000);
    check("wrap_stp_st", {16'h0, st_q[3]}, 32'h0120);
    check("wrap_evp_st", {16'h0, st_q[4]}, 32'h0220);

    // Result back-pressure: slot0 at x=3 is 34.
    result_free_space = '0;
    push_cmd(8'h02, 3'd0, 5'd1);
    dq.push_back(16'd3);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp_hold_start", result_out, 32'd34);
    repeat (10) @(negedge clk);
    check("bp_hold_end", result_out, 32'd34);
    check("bp_no_write", res_q.size(), 32'd3);
    @(posedge clk); #1 result_free_space = 11'd5;
    wait_status(6);
    check("bp_one_write", res_q.size(), 32'd4);
    check("bp_value", res_q[3], 32'd34);
    check("bp_status", {16'h0, st_q[5]}, 32'h0200);

    // Invalid opcode consumes no data.
    dp0 = dpops;
    push_cmd(8'hFF, 3'd0, 5'd3);
    wait_status(7);
    check("cmd_status", {16'h0, st_q[6]}, 32'hFF01);
    check("cmd_pops", dpops - dp0, 32'd0);

    // Degree 12 exceeds the limit: 13 tokens drained.
    dp0 = dpops;
    push_cmd(8'h01, 3'd2, 5'd12);
    for (int i = 0; i < 13; i++) dq.push_back(16'(i + 1));
    wait_status(8);
    check("deg_status", {16'h0, st_q[7]}, 32'h0143);
    check("deg_pops", dpops - dp0, 32'd13);

    // Clear slot1, evaluate it with M=0, then M=0 on valid slot0.
    r0 = res_q.size();
    push_cmd(8'h03, 3'd1, 5'd0);
    push_cmd(8'h02, 3'd1, 5'd0);
    push_cmd(8'h02, 3'd0, 5'd0);
    wait_status(11);
    check("clr_status", {16'h0, st_q[8]}, 32'h0320);
    check("cleared_undef", {16'h0, st_q[9]}, 32'h0222);
    check("m0_status", {16'h0, st_q[10]}, 32'h0200);
    check("m0_nores", res_q.size() - r0, 32'd0);

    // Reset while the MAC is running.
    dp0 = dpops;
    push_cmd(8'h02, 3'd0, 5'd1);
    dq.push_back(16'd5);
    t = 0;
    while (dpops == dp0 && t < 50) begin @(negedge clk); t++; end
    check("mid_x_popped", dpops - dp0, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    s0 = st_q.size(); r0 = res_q.size();
    repeat (10) @(posedge clk);
    check("abandon_status", st_q.size() - s0, 32'd0);
    check("abandon_result", res_q.size() - r0, 32'd0);
    push_cmd(8'h02, 3'd0, 5'd1);
    dq.push_back(16'd9);
    wait_status(s0 + 1);
    check("post_rst_undef", {16'h0, st_q[s0]}, 32'h0202);
    check("post_rst_nores", res_q.size() - r0, 32'd0);

    check("fifo_protocol", viol, 32'd0);
    check("strobe_in_rst", strobe_in_rst, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
